pixel_mixer: RTL and testbench
==============================

Name: pixel_mixer

Overview:
- Output stage downstream of the level generator and the duck sprite renderer.
- Merges duck, obstacle and level 4-bit pixel indices by priority and maps the winning index through a palette to 8-bit VGA RGB (3-3-2).
- Detects duck/obstacle overlap and runs a hit-flash / game-over sequence that the top-level state logic consumes.

Parameters:
- H_START, 144, first visible hc
- H_END, 783, last visible hc
- V_START, 35, first visible vc
- V_END, 514, last visible vc
- FLASH_FRAMES, 8, frames of hit-flash before game over (1..255)

Ports:
- CLK  in  1  system clock (100 MHz); hc/vc advance at 25 MHz, so each hc/vc value is held for 4 CLK cycles
- RESET  in  1  synchronous, active-high reset
- hc  in  10  horizontal counter
- vc  in  10  vertical counter
- game_running  in  1  high in RUN/JUMP/DUCK states
- restart  in  1  level; leaves OVER
- duck_pix  in  4  duck sprite index; 0 = transparent
- obstacle_pix  in  4  obstacle index; 0 = transparent
- level_pix  in  4  ground index; 0 = transparent
- rgb  out  8  {R[2:0],G[2:0],B[1:0]}; 0 outside the visible window
- collision  out  1  one-CLK pulse on the first hit
- flash_active  out  1  high in FLASH
- game_over  out  1  high in OVER

Behaviour:
- All outputs reset to 0. FSM resets to RUN. Frame counter resets to 0. Edge register resets to 0.
- Visible: H_START<=hc<=H_END && V_START<=vc<=V_END, all comparisons unsigned.
- Pipeline: 2 CLK latency from inputs to rgb; the pipeline runs continuously in every state.
- Stage 1 registers visible and the selected index.
- Priority: duck_pix!=0 wins, else obstacle_pix!=0, else level_pix, else 0.
- Stage 2 registers rgb = visible ? palette(index) : 0.
- Palette (decided values): 0 -> 8'h00; 4'b0111 -> 8'hB6 ground; 4'b1000 -> 8'hE0 obstacle; 4'b0001..4'b0110 -> duck colours 8'hFC, 8'hF4, 8'hFF, 8'h24, 8'h1C, 8'h03; all other indices -> 8'h00.
- frame_tick: one-CLK pulse on the rising edge of (hc==0 && vc==0), using an edge register. It must not fire 4 times per frame.
- hit (combinational from inputs): visible && game_running && duck_pix!=0 && obstacle_pix!=0.
- FSM:
  - RUN: on hit, collision=1 for exactly that cycle, frame counter cleared, go to FLASH. restart is ignored.
  - FLASH: flash_active=1. The frame counter increments on frame_tick. Stage-2 output is inverted (~rgb, visible pixels only) while counter[0]==1. When frame_tick arrives with counter==FLASH_FRAMES-1, go to OVER. hit is ignored; no further collision pulses.
  - OVER: game_over=1, rgb not inverted. If restart==1, go to RUN next cycle and clear the counter.
- flash_active, game_over and the inversion select are registered from the FSM state, so they are aligned with the rgb of the same cycle. collision is registered, 1 CLK after the hit inputs.
- Reset mid-FLASH or mid-OVER: next cycle is RUN with all outputs 0. Pipeline registers clear, so rgb=0 for 2 cycles.
- A hit and frame_tick in the same cycle in RUN: the hit takes effect and the counter starts at 0; that tick is not counted.
- Counter width is 8 bits; no wrap is possible within the legal FLASH_FRAMES range.

Optional Feature:
- Macro: PIXEL_MIXER_HITBOX_DEBUG_EN.
- Defined: any visible pixel where duck_pix!=0 && obstacle_pix!=0 is forced to 8'hE3 (magenta) in stage 2 in all states, overriding priority and inversion.
- Undefined: normal priority applies; no extra logic.

Decomposition:
- Shared package ducking_pkg holds:
  - palette index constants: IDX_NONE, IDX_GROUND=4'b0111, IDX_OBSTACLE=4'b1000, duck indices
  - RGB colour constants
  - mixer FSM state enum: RUN, FLASH, OVER
  - visible-window default constants
- One sub-module: pixel_palette, a purely combinational index->rgb LUT instantiated in stage 2.

Test Plan:
- Visible pixel (hc=300, vc=308) with level_pix=7, others 0 -> rgb=8'hB6 exactly 2 CLK later. Same inputs at hc=100 -> rgb=0.
- duck_pix=1, obstacle_pix=8, level_pix=7 at hc=400, vc=200, game_running=0 -> rgb=8'hFC, collision stays 0, FSM stays RUN.
- Same inputs with game_running=1 -> collision high for exactly 1 CLK, flash_active=1. Overlap held 20 more cycles -> no second pulse.
- In FLASH, drive 8 frames (hc=vc=0 held 4 CLK each) -> inversion on odd frames (ground pixel rgb=8'h49). After the 8th tick, game_over=1, flash_active=0.
- In OVER, restart=1 -> RUN next cycle, game_over=0. A new overlap produces a new collision pulse.
- RESET asserted mid-FLASH -> next cycle all outputs 0, state RUN. hc=vc=0 held 4 CLK -> frame counter advances exactly once.

Source files
------------

// File: rtl/ducking_pkg.sv
// Shared definitions for the ducking game video path: palette indices, RGB colours,
// mixer FSM states and default visible-window bounds.
package ducking_pkg;

  localparam logic [3:0] IDX_NONE      = 4'b0000;
  localparam logic [3:0] IDX_DUCK_BODY = 4'b0001;
  localparam logic [3:0] IDX_DUCK_BEAK = 4'b0010;
  localparam logic [3:0] IDX_DUCK_EYE  = 4'b0011;
  localparam logic [3:0] IDX_DUCK_PUPL = 4'b0100;
  localparam logic [3:0] IDX_DUCK_WING = 4'b0101;
  localparam logic [3:0] IDX_DUCK_TAIL = 4'b0110;
  localparam logic [3:0] IDX_GROUND    = 4'b0111;
  localparam logic [3:0] IDX_OBSTACLE  = 4'b1000;

  localparam logic [7:0] RGB_BLACK     = 8'h00;
  localparam logic [7:0] RGB_GROUND    = 8'hB6;
  localparam logic [7:0] RGB_OBSTACLE  = 8'hE0;
  localparam logic [7:0] RGB_YELLOW    = 8'hFC;
  localparam logic [7:0] RGB_ORANGE    = 8'hF4;
  localparam logic [7:0] RGB_WHITE     = 8'hFF;
  localparam logic [7:0] RGB_DARK      = 8'h24;
  localparam logic [7:0] RGB_GREEN     = 8'h1C;
  localparam logic [7:0] RGB_BLUE      = 8'h03;
  localparam logic [7:0] RGB_HITBOX    = 8'hE3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } mixer_state_t;

  localparam logic [9:0] H_START_DEF = 10'd144;
  localparam logic [9:0] H_END_DEF   = 10'd783;
  localparam logic [9:0] V_START_DEF = 10'd35;
  localparam logic [9:0] V_END_DEF   = 10'd514;

endpackage

// File: rtl/pixel_palette.sv
// Combinational palette LUT: 4-bit pixel index to 3-3-2 RGB.
module pixel_palette
  import ducking_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] rgb
);

  always_comb begin
    unique case (idx)
      IDX_DUCK_BODY: rgb = RGB_YELLOW;
      IDX_DUCK_BEAK: rgb = RGB_ORANGE;
      IDX_DUCK_EYE:  rgb = RGB_WHITE;
      IDX_DUCK_PUPL: rgb = RGB_DARK;
      IDX_DUCK_WING: rgb = RGB_GREEN;
      IDX_DUCK_TAIL: rgb = RGB_BLUE;
      IDX_GROUND:    rgb = RGB_GROUND;
      IDX_OBSTACLE:  rgb = RGB_OBSTACLE;
      default:       rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/pixel_mixer.sv
// Priority pixel mixer with palette lookup and hit-flash / game-over sequencing.
// Optional PIXEL_MIXER_HITBOX_DEBUG_EN paints duck/obstacle overlap magenta.
module pixel_mixer
  import ducking_pkg::*;
#(
  parameter logic [9:0]  H_START      = H_START_DEF,
  parameter logic [9:0]  H_END        = H_END_DEF,
  parameter logic [9:0]  V_START      = V_START_DEF,
  parameter logic [9:0]  V_END        = V_END_DEF,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       game_running,
  input  logic       restart,
  input  logic [3:0] duck_pix,
  input  logic [3:0] obstacle_pix,
  input  logic [3:0] level_pix,
  output logic [7:0] rgb,
  output logic       collision,
  output logic       flash_active,
  output logic       game_over
);

  localparam logic [7:0] CNT_LAST = 8'(FLASH_FRAMES - 1);

  mixer_state_t state, state_n;
  logic [7:0]   cnt, cnt_n;
  logic         col_n, inv_n;
  logic         vis, origin, origin_q, frame_tick, hit;
  logic [3:0]   idx;
  logic         vis1;
  logic [3:0]   idx1;
  logic [7:0]   pal, rgb_n;

  assign vis = (hc >= H_START) && (hc <= H_END) && (vc >= V_START) && (vc <= V_END);
  assign origin = (hc == '0) && (vc == '0);
  // Counters dwell 4 CLK per value; the edge register keeps one tick per frame.
  assign frame_tick = origin && !origin_q;
  assign hit = vis && game_running && (duck_pix != IDX_NONE) && (obstacle_pix != IDX_NONE);

  always_comb begin
    if (duck_pix != IDX_NONE)          idx = duck_pix;
    else if (obstacle_pix != IDX_NONE) idx = obstacle_pix;
    else                               idx = level_pix;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = 1'b0;
    unique case (state)
      RUN: if (hit) begin
        col_n   = 1'b1;
        cnt_n   = '0;
        state_n = FLASH;
      end
      FLASH: if (frame_tick) begin
        if (cnt == CNT_LAST) state_n = OVER;
        else                 cnt_n   = cnt + 8'd1;
      end
      OVER: if (restart) begin
        state_n = RUN;
        cnt_n   = '0;
      end
      default: state_n = RUN;
    endcase
  end

  // Inversion follows the next state so it lines up with flash_active on the same cycle.
  assign inv_n = (state_n == FLASH) && cnt_n[0];

  pixel_palette u_palette (
    .idx (idx1),
    .rgb (pal)
  );

`ifdef PIXEL_MIXER_HITBOX_DEBUG_EN
  logic ovl1;

  always_comb begin
    rgb_n = '0;
    if (vis1 && ovl1) rgb_n = RGB_HITBOX;
    else if (vis1)    rgb_n = inv_n ? ~pal : pal;
  end
`else
  always_comb begin
    rgb_n = '0;
    if (vis1) rgb_n = inv_n ? ~pal : pal;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= RUN;
      cnt          <= '0;
      origin_q     <= 1'b0;
      vis1         <= 1'b0;
      idx1         <= '0;
      rgb          <= '0;
      collision    <= 1'b0;
      flash_active <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      origin_q     <= origin;
      vis1         <= vis;
      idx1         <= idx;
      rgb          <= rgb_n;
      collision    <= col_n;
      flash_active <= (state_n == FLASH);
      game_over    <= (state_n == OVER);
    end
  end

`ifdef PIXEL_MIXER_HITBOX_DEBUG_EN
  always_ff @(posedge CLK) begin
    if (RESET) ovl1 <= 1'b0;
    else       ovl1 <= (duck_pix != IDX_NONE) && (obstacle_pix != IDX_NONE);
  end
`endif

endmodule

// File: tb/tb_pixel_mixer.sv
// Scoreboard bench for pixel_mixer: directed vectors push hand-computed expectations,
// a negedge monitor compares rgb (2 CLK after inputs) and flags (1 CLK after inputs).
module tb_pixel_mixer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] hc = '0, vc = '0;
  logic       game_running = 1'b0, restart = 1'b0;
  logic [3:0] duck_pix = '0, obstacle_pix = '0, level_pix = '0;
  logic [7:0] rgb;
  logic       collision, flash_active, game_over;

  pixel_mixer #(
    .H_START      (10'd144),
    .H_END        (10'd783),
    .V_START      (10'd35),
    .V_END        (10'd514),
    .FLASH_FRAMES (8)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .hc           (hc),
    .vc           (vc),
    .game_running (game_running),
    .restart      (restart),
    .duck_pix     (duck_pix),
    .obstacle_pix (obstacle_pix),
    .level_pix    (level_pix),
    .rgb          (rgb),
    .collision    (collision),
    .flash_active (flash_active),
    .game_over    (game_over)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    bit         is_rgb;
    logic [7:0] rgb;
    logic [2:0] flags;   // {collision, flash_active, game_over}
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        tests++;
        if (sb[i].due < cyc) begin
          fails++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", sb[i].nm, sb[i].due, cyc);
        end else if (sb[i].is_rgb) begin
          if (rgb !== sb[i].rgb) begin
            fails++;
            $display("FAIL %s rgb @%0d: got %h, expected %h", sb[i].nm, cyc, rgb, sb[i].rgb);
          end
        end else if ({collision, flash_active, game_over} !== sb[i].flags) begin
          fails++;
          $display("FAIL %s flags{col,flash,over} @%0d: got %b, expected %b",
                   sb[i].nm, cyc, {collision, flash_active, game_over}, sb[i].flags);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic [3:0] d,
                      input logic [3:0] o, input logic [3:0] l, input logic gr,
                      input logic rs, input logic rst, input logic [7:0] er,
                      input logic [2:0] ef, input string nm);
    exp_t e;
    hc = h; vc = v; duck_pix = d; obstacle_pix = o; level_pix = l;
    game_running = gr; restart = rs; RESET = rst;
    e.nm = nm;
    e.is_rgb = 1'b0; e.rgb = '0; e.flags = ef; e.due = cyc + 1;
    sb.push_back(e);
    e.is_rgb = 1'b1; e.rgb = er; e.flags = '0; e.due = cyc + 2;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) step(10, 10, 0, 0, 0, 0, 0, 1, 8'h00, 3'b000, "reset");

    repeat (2) step(300, 308, 0, 0, 7, 0, 0, 0, 8'hB6, 3'b000, "ground");
    step(100, 308, 0, 0, 7, 0, 0, 0, 8'h00, 3'b000, "left_blank");

    step(144,  35, 0, 0, 7, 0, 0, 0, 8'hB6, 3'b000, "win_tl");
    step(143,  35, 0, 0, 7, 0, 0, 0, 8'h00, 3'b000, "win_h_lo");
    step(144,  34, 0, 0, 7, 0, 0, 0, 8'h00, 3'b000, "win_v_lo");
    step(783, 514, 0, 0, 7, 0, 0, 0, 8'hB6, 3'b000, "win_br");
    step(784, 514, 0, 0, 7, 0, 0, 0, 8'h00, 3'b000, "win_h_hi");
    step(783, 515, 0, 0, 7, 0, 0, 0, 8'h00, 3'b000, "win_v_hi");

    repeat (2) step(400, 200, 1, 8, 7, 0, 0, 0, 8'hFC, 3'b000, "overlap_idle");
    step(400, 200, 0, 8, 7, 0, 0, 0, 8'hE0, 3'b000, "obst_over_ground");
    step(400, 200, 0, 8, 0, 0, 0, 0, 8'hE0, 3'b000, "obst_only");
    step(400, 200, 6, 0, 7, 0, 0, 0, 8'h03, 3'b000, "duck6");
    step(400, 200, 3, 8, 0, 0, 0, 0, 8'hFF, 3'b000, "duck3");
    step(400, 200, 2, 0, 0, 0, 0, 0, 8'hF4, 3'b000, "duck2");
    step(400, 200, 4, 0, 0, 0, 0, 0, 8'h24, 3'b000, "duck4");
    step(400, 200, 5, 0, 0, 0, 0, 0, 8'h1C, 3'b000, "duck5");
    step(400, 200, 0, 0, 9, 0, 0, 0, 8'h00, 3'b000, "idx9");
    step(400, 200, 0, 0, 0, 0, 0, 0, 8'h00, 3'b000, "idx0");
    step(100, 200, 1, 8, 7, 1, 0, 0, 8'h00, 3'b000, "overlap_blank");

    step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b110, "hit");
    repeat (20) step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b010, "hit_hold");
    step(100, 308, 0, 0, 7, 1, 0, 0, 8'h00, 3'b010, "pre_frames");

    for (int f = 1; f <= 8; f++) begin
      logic [2:0] fl;
      logic [7:0] g;
      fl = (f < 8) ? 3'b010 : 3'b001;
      g  = (f < 8 && (f % 2) == 1) ? 8'h49 : 8'hB6;
      repeat (4) step(0, 0, 0, 0, 7, 1, 0, 0, 8'h00, fl, $sformatf("frame%0d_origin", f));
      repeat (2) step(300, 308, 0, 0, 7, 1, 0, 0, g, fl, $sformatf("frame%0d_ground", f));
      step(100, 308, 0, 0, 7, 1, 0, 0, 8'h00, fl, $sformatf("frame%0d_blank", f));
    end

    repeat (2) step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b001, "over_overlap");
    step(100, 308, 0, 0, 7, 0, 1, 0, 8'h00, 3'b000, "restart");
    step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b110, "rehit");
    step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b010, "rehit_hold");
    // Its pixel lands on the reset edge, so it is cleared.
    step(400, 200, 1, 8, 7, 1, 0, 0, 8'h00, 3'b010, "pre_reset");
    step(300, 308, 0, 0, 7, 1, 0, 1, 8'h00, 3'b000, "mid_flash_reset");
    repeat (2) step(300, 308, 0, 0, 7, 0, 0, 0, 8'hB6, 3'b000, "post_reset");
    repeat (4) step(0, 0, 0, 0, 7, 1, 0, 0, 8'h00, 3'b000, "run_origin");
    step(300, 308, 0, 0, 7, 1, 0, 0, 8'hB6, 3'b000, "run_ground");
    step(400, 200, 1, 8, 7, 1, 0, 0, 8'hFC, 3'b110, "hit_after_reset");
    step(100, 308, 0, 0, 7, 0, 0, 0, 8'h00, 3'b010, "tail");

    repeat (3) @(posedge CLK);
    #6;
    if (sb.size() != 0) begin
      fails += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
